// File: rtl/counter8_pkg.sv
// Shared constants and types for the modulo-8 event counter slice.
package counter8_pkg;

    localparam int COUNT_W_DEF = 3;
    localparam int COUNT_MAX   = 2**COUNT_W_DEF - 1;

    typedef logic [COUNT_W_DEF-1:0] count_t;

endpackage

// File: rtl/counter8_overflow_unit_if.sv
// Event-enable / status bundle between a controller and the counter unit.
interface counter8_overflow_unit_if;

    logic count_7;
    logic q;
    logic overflow;

    modport master (output count_7, input  q, input  overflow);
    modport slave  (input  count_7, output q, output overflow);

endinterface

// File: rtl/counter8_overflow_unit_mod_counter.sv
// Width-parameterised enable counter with a combinational terminal-count term.
module mod_counter #(
    parameter int W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count;

    // Advance on enabled edges; natural unsigned wrap from MAX to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count: this edge will wrap the counter.
    always_comb begin
        tc = en && (count == MAX);
    end

endmodule

// File: rtl/counter8_overflow_unit.sv
// Modulo-8 event counter: one-cycle overflow pulse and toggle output on each wrap.
module counter8_overflow_unit
    import counter8_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    counter8_overflow_unit_if.slave  bus
);

    logic tc;
    logic q_r;
    logic overflow_r;

    mod_counter #(.W(COUNT_W)) u_mod_counter (
        .clk   (clk),
        .reset (reset),
        .en    (bus.count_7),
        .tc    (tc)
    );

    // Register the wrap event so neither output has a path from count_7.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r        <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= tc;
            q_r        <= q_r ^ tc;
        end
    end

    assign bus.q        = q_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_counter8_overflow_unit.sv
// Scoreboard bench: stimulus pushes expected outputs, monitor pops and compares.
module tb_counter8_overflow_unit;

    typedef struct {
        logic q;
        logic ov;
        int   phase;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    counter8_overflow_unit_if bus ();

    counter8_overflow_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_enabled = 0;
    int   mon_cycle = 0;
    int   pulses = 0;
    int   pulse_cyc[$];
    logic last_q = 1'b0;

    // Reference: outputs follow from the number of enabled edges since reset.
    task automatic step(input logic r, input logic en, input int phase);
        exp_t e;
        @(negedge clk);
        reset       = r;
        bus.count_7 = en;
        e.phase = phase;
        if (r) begin
            n_enabled = 0;
            e.ov = 1'b0;
        end else if (en === 1'b1) begin
            n_enabled = n_enabled + 1;
            e.ov = (n_enabled % 8 == 0);
        end else begin
            e.ov = 1'b0;
        end
        e.q = ((n_enabled / 8) % 2) == 1;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_pulses();
        pulses = 0;
        pulse_cyc.delete();
    endtask

    // Monitor: one output sample per cycle, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.q !== e.q || bus.overflow !== e.ov) begin
                    errors++;
                    $display("FAIL phase%0d_cyc%0d q=%b ov=%b required q=%b ov=%b",
                             e.phase, mon_cycle, bus.q, bus.overflow, e.q, e.ov);
                end
                if (bus.overflow === 1'b1) begin
                    pulses++;
                    pulse_cyc.push_back(mon_cycle);
                end
                last_q = bus.q;
            end
        end
    end

    initial begin
        bus.count_7 = 1'b0;

        // 1: reset with an unknown enable
        step(1'b1, 1'bx, 1);

        // 2: eight enabled edges then one more
        clear_pulses();
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 2);
        drain();
        check("p2_pulses", pulses, 1);

        // 3: alternating enable over 16 cycles
        step(1'b1, 1'b0, 3);
        drain();
        clear_pulses();
        for (int i = 0; i < 16; i++) step(1'b0, logic'(i % 2), 3);
        drain();
        check("p3_pulses", pulses, 1);
        check("p3_q_end", int'(last_q), 1);

        // 4: sixteen consecutive enabled edges
        step(1'b1, 1'b0, 4);
        drain();
        clear_pulses();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4);
        drain();
        check("p4_pulses", pulses, 2);
        if (pulse_cyc.size() == 2) check("p4_gap", pulse_cyc[1] - pulse_cyc[0], 8);
        check("p4_q_end", int'(last_q), 0);

        // 5: reset after five counts, then a full cycle
        step(1'b1, 1'b0, 5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5);
        step(1'b1, 1'b1, 5);
        drain();
        clear_pulses();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5);
        drain();
        check("p5_pulses", pulses, 1);

        // 6: reset lands on the wrap edge
        step(1'b1, 1'b0, 6);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 6);
        drain();
        clear_pulses();
        step(1'b1, 1'b1, 6);
        step(1'b0, 1'b0, 6);
        drain();
        check("p6_pulses", pulses, 0);
        check("p6_q", int'(last_q), 0);

        // 7: random enables with occasional resets
        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)), 7);
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
